// File: rtl/descrypt_result_arbiter_pkg.sv
// descrypt_result_arbiter_pkg: shared field widths and packed result-record layout
// so the downstream packet builder can decode arbiter output.
package descrypt_result_arbiter_pkg;
    localparam int RAM_ADDR_MSB = 11;
    localparam int NUM_BATCHES_MSB = 15;
    localparam int NUM_PKTS_MSB = 15;
    localparam int RAM_W = RAM_ADDR_MSB + 1;
    localparam int BATCH_W = NUM_BATCHES_MSB + 1;
    localparam int PKT_W = NUM_PKTS_MSB + 1;
    localparam int REC_INST_LSB = RAM_W;

    function automatic int msb(input int x);
        int r;
        r = 0;
        for (int b = 0; b < 31; b++) if (x[b]) r = b;
        return r;
    endfunction

    function automatic int idx_w(input int n);
        return msb(n - 1) + 1;
    endfunction

    // Record layout, LSB first: ram_addr, instance, equal, key_valid,
    // batch_complete, batch_num, pkt_num, core_num.
    function automatic int rec_equal_bit(input int ni);
        return RAM_W + idx_w(ni);
    endfunction

    function automatic int rec_key_valid_bit(input int ni);
        return rec_equal_bit(ni) + 1;
    endfunction

    function automatic int rec_batch_complete_bit(input int ni);
        return rec_equal_bit(ni) + 2;
    endfunction

    function automatic int rec_batch_lsb(input int ni);
        return rec_equal_bit(ni) + 3;
    endfunction

    function automatic int rec_pkt_lsb(input int ni);
        return rec_batch_lsb(ni) + BATCH_W;
    endfunction

    function automatic int rec_core_lsb(input int ni);
        return rec_pkt_lsb(ni) + PKT_W;
    endfunction

    function automatic int rec_w(input int nc, input int ni);
        return rec_core_lsb(ni) + idx_w(nc);
    endfunction
endpackage

// File: rtl/descrypt_result_arbiter_if.sv
// descrypt_result_arbiter_if: per-core comparator results in, merged tagged
// record stream and status out.
interface descrypt_result_arbiter_if
    import descrypt_result_arbiter_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int NUM_CRYPT_INSTANCES = 16,
    parameter int EQ_CNT_WIDTH = 16
);
    localparam int IW = idx_w(NUM_CRYPT_INSTANCES);
    localparam int REC_W = rec_w(NUM_CORES, NUM_CRYPT_INSTANCES);
    logic [NUM_CORES*RAM_W-1:0] core_dout;
    logic [NUM_CORES*IW-1:0] core_instance;
    logic [NUM_CORES-1:0] core_equal;
    logic [NUM_CORES-1:0] core_key_valid;
    logic [NUM_CORES-1:0] core_batch_complete;
    logic [NUM_CORES-1:0] core_wr_en;
    logic [NUM_CORES*BATCH_W-1:0] core_batch_num;
    logic [NUM_CORES*PKT_W-1:0] core_pkt_num;
    logic [NUM_CORES-1:0] core_full;
    logic [REC_W-1:0] out_data;
    logic out_wr_en;
    logic out_full;
    logic idle;
    logic [NUM_CORES-1:0] overflow_err;
    logic [EQ_CNT_WIDTH-1:0] eq_count;

    modport master (
        output core_dout, core_instance, core_equal, core_key_valid, core_batch_complete,
        output core_wr_en, core_batch_num, core_pkt_num, out_full,
        input core_full, out_data, out_wr_en, idle, overflow_err, eq_count
    );

    modport slave (
        input core_dout, core_instance, core_equal, core_key_valid, core_batch_complete,
        input core_wr_en, core_batch_num, core_pkt_num, out_full,
        output core_full, out_data, out_wr_en, idle, overflow_err, eq_count
    );
endinterface

// File: rtl/descrypt_result_arbiter_rr_arbiter.sv
// descrypt_result_arbiter_rr_arbiter: N-way round-robin; grants the first
// requester after the last accepted index, wrapping.
module descrypt_result_arbiter_rr_arbiter
    import descrypt_result_arbiter_pkg::*;
#(
    parameter int N = 4,
    localparam int W = idx_w(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         accept,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         any
);
    logic [W-1:0] ptr_q, ptr_d;

    // Pass 0 scans above the pointer, pass 1 wraps to the pointer itself.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int p = 0; p < 2; p++)
            for (int j = 0; j < N; j++)
                if (!any && req[j] && ((j > int'(ptr_q)) == (p == 0))) begin
                    any = 1'b1;
                    idx = W'(j);
                    gnt[j] = 1'b1;
                end
        ptr_d = accept ? idx : ptr_q;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) ptr_q <= W'(N - 1);
        else ptr_q <= ptr_d;
endmodule

// File: rtl/descrypt_result_arbiter.sv
// descrypt_result_arbiter: one holding slot per core, round-robin merge into a
// tagged record stream, sticky overflow flags and saturating equal counter.
module descrypt_result_arbiter
    import descrypt_result_arbiter_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int NUM_CRYPT_INSTANCES = 16,
    parameter int EQ_CNT_WIDTH = 16
) (
    input logic CMP_CLK,
    input logic RESET,
    descrypt_result_arbiter_if.slave bus
);
    localparam int IW = idx_w(NUM_CRYPT_INSTANCES);
    localparam int CW = idx_w(NUM_CORES);
    localparam int PAY_W = rec_core_lsb(NUM_CRYPT_INSTANCES);
    localparam int EQ_BIT = rec_equal_bit(NUM_CRYPT_INSTANCES);

    logic [PAY_W-1:0] pay [NUM_CORES];
    logic [PAY_W-1:0] slot_q [NUM_CORES];
    logic [PAY_W-1:0] slot_d [NUM_CORES];
    logic [NUM_CORES-1:0] occ_q, occ_d, ovf_q, ovf_d, req, gnt;
    logic [CW+PAY_W-1:0] out_data_q, out_data_d;
    logic out_wr_en_q, out_wr_en_d, idle_q, idle_d, any;
    logic [EQ_CNT_WIDTH-1:0] eq_count_q, eq_count_d;
    logic [CW-1:0] idx;

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_pay
        assign pay[g] = {bus.core_pkt_num[g*PKT_W +: PKT_W], bus.core_batch_num[g*BATCH_W +: BATCH_W],
                         bus.core_batch_complete[g], bus.core_key_valid[g], bus.core_equal[g],
                         bus.core_instance[g*IW +: IW], bus.core_dout[g*RAM_W +: RAM_W]};
    end

    assign req = bus.out_full ? '0 : occ_q;

    descrypt_result_arbiter_rr_arbiter #(.N(NUM_CORES)) u_arb (
        .clk(CMP_CLK),
        .rst(RESET),
        .req(req),
        .accept(any),
        .gnt(gnt),
        .idx(idx),
        .any(any)
    );

    // A write into an occupied slot (even one being granted) is dropped and flagged.
    always_comb begin
        occ_d = occ_q;
        ovf_d = ovf_q;
        slot_d = slot_q;
        for (int i = 0; i < NUM_CORES; i++) begin
            occ_d[i] = occ_q[i] ? ~gnt[i] : bus.core_wr_en[i];
            ovf_d[i] = ovf_q[i] | (occ_q[i] & bus.core_wr_en[i]);
            slot_d[i] = (occ_q[i] | ~bus.core_wr_en[i]) ? slot_q[i] : pay[i];
        end
        out_wr_en_d = any;
        idle_d = ~|occ_d;
        out_data_d = any ? {idx, slot_q[idx]} : out_data_q;
        eq_count_d = (any && slot_q[idx][EQ_BIT] && !(&eq_count_q)) ? eq_count_q + EQ_CNT_WIDTH'(1) : eq_count_q;
    end

    always_ff @(posedge CMP_CLK or posedge RESET)
        if (RESET) begin
            occ_q <= '0;
            ovf_q <= '0;
            slot_q <= '{default: '0};
            out_wr_en_q <= 1'b0;
            idle_q <= 1'b1;
            out_data_q <= '0;
            eq_count_q <= '0;
        end else begin
            occ_q <= occ_d;
            ovf_q <= ovf_d;
            slot_q <= slot_d;
            out_wr_en_q <= out_wr_en_d;
            idle_q <= idle_d;
            out_data_q <= out_data_d;
            eq_count_q <= eq_count_d;
        end

    assign bus.core_full = occ_q;
    assign bus.out_data = out_data_q;
    assign bus.out_wr_en = out_wr_en_q;
    assign bus.idle = idle_q;
    assign bus.overflow_err = ovf_q;
    assign bus.eq_count = eq_count_q;
endmodule
